// File: rtl/channel_deinterleaver_if.sv
// Serial-sample input stream and parallel-group output stream of the channel deinterleaver.
// master drives samples and consumes groups; slave is the deinterleaver itself.
interface channel_deinterleaver_if #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_CHANNELS = 4
);
  logic [DATA_WIDTH-1:0]              in_data;
  logic                               in_first;
  logic                               in_valid;
  logic                               in_ready;
  logic [DATA_WIDTH*NUM_CHANNELS-1:0] out_data;
  logic                               out_valid;
  logic                               out_ready;
  logic                               err_misalign;
  logic [7:0]                         drop_count;

  modport master (
    output in_data, in_first, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err_misalign, drop_count
  );

  modport slave (
    input  in_data, in_first, in_valid, out_ready,
    output in_ready, out_data, out_valid, err_misalign, drop_count
  );
endinterface

// File: rtl/channel_deinterleaver.sv
// Collects NUM_CHANNELS serial samples into one parallel group, resynchronising on in_first
// and counting discarded partial groups.
module channel_deinterleaver #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_CHANNELS = 4
) (
  input  logic clk,
  input  logic rst,
  channel_deinterleaver_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_CHANNELS);
  localparam int unsigned BUF_W = DATA_WIDTH * (NUM_CHANNELS - 1);
  localparam int unsigned OUT_W = DATA_WIDTH * NUM_CHANNELS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  logic [IDX_W-1:0] ch_idx, ch_idx_nxt;
  logic [BUF_W-1:0] buffer, buffer_nxt;
  logic [OUT_W-1:0] out_data_q, out_data_nxt;
  logic             out_valid_q, out_valid_nxt;
  logic             err_q, err_nxt;
  logic [7:0]       drop_q, drop_nxt;
  logic             at_last, in_beat, misalign, complete;

  // Only the group-completing beat needs the output register free.
  assign at_last      = (ch_idx == LAST_IDX);
  assign bus.in_ready = !(at_last && out_valid_q && !bus.out_ready);
  assign in_beat      = bus.in_valid && bus.in_ready;
  assign misalign     = in_beat && bus.in_first && (ch_idx != '0);
  assign complete     = in_beat && !misalign && at_last;

  always_comb begin
    ch_idx_nxt    = ch_idx;
    buffer_nxt    = buffer;
    out_data_nxt  = out_data_q;
    out_valid_nxt = out_valid_q;
    err_nxt       = 1'b0;
    drop_nxt      = drop_q;

    if (misalign) begin
      buffer_nxt[DATA_WIDTH-1:0] = bus.in_data;
      ch_idx_nxt                 = IDX_W'(1);
      err_nxt                    = 1'b1;
      if (drop_q != 8'hFF) drop_nxt = drop_q + 8'd1;
    end else if (complete) begin
      out_data_nxt = {bus.in_data, buffer};
      ch_idx_nxt   = '0;
    end else if (in_beat) begin
      for (int k = 0; k < int'(NUM_CHANNELS) - 1; k++) begin
        if (ch_idx == IDX_W'(k)) buffer_nxt[k*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
      end
      ch_idx_nxt = ch_idx + IDX_W'(1);
    end

    // A reload in the same cycle as an output beat keeps out_valid high.
    if (complete)           out_valid_nxt = 1'b1;
    else if (bus.out_ready) out_valid_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_idx      <= '0;
      buffer      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= '0;
    end else begin
      ch_idx      <= ch_idx_nxt;
      buffer      <= buffer_nxt;
      out_data_q  <= out_data_nxt;
      out_valid_q <= out_valid_nxt;
      err_q       <= err_nxt;
      drop_q      <= drop_nxt;
    end
  end

  assign bus.out_data     = out_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.err_misalign = err_q;
  assign bus.drop_count   = drop_q;
endmodule
